// File: rtl/vm_keypad_pkg.sv
// rtl/vm_keypad_pkg.sv - shared types, constants and decode helpers for the keypad scanner
package vm_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        EMIT      = 2'd2,
        WAIT_REL  = 2'd3
    } kp_state_e;

    localparam logic [3:0] COL_RESET  = 4'b1110;
    localparam logic [3:0] ROW_IDLE   = 4'b1111;
    localparam int         KEY_CODE_W = 4;

    // Position of the single low bit in an active-low one-hot vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider producing a one-clk tick every CLK_DIV clks
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad scanner with press/release debounce; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scan_ctrl
    import vm_keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 20
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_TICKS   = 500
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            row,
    output logic [3:0]            shift_col,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic                  tick;
    logic [3:0]            row_m_q, row_s_q;
    kp_state_e             state_q, state_d;
    logic [3:0]            col_q, col_d;
    logic [3:0]            lat_row_q, lat_row_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  held_q, held_d;
    logic                  armed_q, armed_d;
    logic [3:0]            col_rot;
`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0]      rep_q, rep_d;
`endif

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_m_q <= ROW_IDLE;
            row_s_q <= ROW_IDLE;
        end else begin
            row_m_q <= row;
            row_s_q <= row_m_q;
        end
    end

    assign col_rot = {col_q[2:0], col_q[3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            col_q     <= COL_RESET;
            lat_row_q <= ROW_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            held_q    <= 1'b0;
            armed_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            lat_row_q <= lat_row_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            held_q    <= held_d;
            armed_q   <= armed_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        lat_row_d = lat_row_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        held_d    = held_q;
        armed_d   = armed_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (row_s_q == ROW_IDLE) begin
                        col_d   = col_rot;
                        armed_d = 1'b1;
                    // A key already down when reset exits is not armed: it waits for release like a ghost.
                    end else if (armed_q && one_low(row_s_q)) begin
                        lat_row_d = row_s_q;
                        cnt_d     = CNT_W'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = EMIT;
                            code_d  = {low_index(col_q), low_index(row_s_q)};
                            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_REL;
                    end
                end
            end
            DEB_PRESS: begin
                if (tick) begin
                    if (row_s_q == lat_row_q) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d = EMIT;
                            code_d  = {low_index(col_q), low_index(lat_row_q)};
                            held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_rot;
                        cnt_d   = '0;
                    end
                end
            end
            EMIT: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
            WAIT_REL: begin
                if (tick) begin
                    if (row_s_q == ROW_IDLE) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d = SCAN;
                            col_d   = col_rot;
                            held_d  = 1'b0;
                            armed_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (held_q && (row_s_q == lat_row_q)) begin
                        if (rep_q == REP_LAST) begin
                            rep_d   = '0;
                            state_d = EMIT;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        shift_col = col_q;
        key_valid = (state_q == EMIT);
        key_code  = code_q;
        key_held  = held_q;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the vending machine's 4x4 matrix keypad. Drives the active-low column strobes and samples the active-low row inputs. Debounces presses and releases, then emits one key event (code plus single-cycle valid) per physical press. Sits between the keypad pins and the vending_machine FSM/display logic, which consume key_code/key_valid.

Parameters:
CLK_DIV, 50000, clk cycles per scan tick; must be at least 4.
DEBOUNCE_TICKS, 20, consecutive stable ticks needed to accept a press or a release; must be at least 1.
REPEAT_TICKS, 500, ticks between auto-repeat events; used only with KEYPAD_REPEAT_EN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
row  in  4  keypad rows, active-low, asynchronous to clk
shift_col  out  4  column strobe, one-hot-low
key_valid  out  1  one-clk pulse, key_code valid
key_code  out  4  {col_idx[1:0], row_idx[1:0]}
key_held  out  1  high from accepted press until release debounce completes

Behaviour:
- Reset (reset=0, async):
  - shift_col=4'b1110, key_valid=0, key_code=0, key_held=0.
  - State=SCAN; tick divider and debounce counter cleared.
  - Reset asserted mid-operation aborts any press immediately. No key_valid is generated on reset exit.
- Row input: 2-flop synchronizer gives row_s.
- Tick: 1-clk strobe every CLK_DIV clks from a free-running divider. All state decisions occur only on tick cycles.
- Column index: col_idx = position of the 0 in shift_col. row_idx = position of the 0 in row_s.
- SCAN, on tick:
  - row_s==1111: rotate shift_col 1110→1101→1011→0111→1110.
  - row_s has exactly one 0: latch row_s and col_idx, cnt=1, go to DEB_PRESS. shift_col freezes.
  - row_s has two or more 0s (ghost/multi-key): no event; go to WAIT_REL.
- DEB_PRESS, on tick:
  - row_s equals latched pattern: cnt++. When cnt==DEBOUNCE_TICKS, go to EMIT.
  - Otherwise (bounce): go to SCAN and rotate column. No event.
- EMIT (exactly 1 clk):
  - key_valid=1.
  - key_code={col_idx,row_idx} registered; holds its value until the next EMIT.
  - key_held=1. Go to WAIT_REL with cnt=0.
- WAIT_REL, on tick:
  - row_s==1111: cnt++; otherwise cnt=0.
  - When cnt==DEBOUNCE_TICKS: key_held=0, go to SCAN, rotate column.
- Latency:
  - The accepting tick is DEBOUNCE_TICKS-1 ticks after the detecting tick, plus sync delay.
  - key_valid asserts the clk after the accepting tick.
- Simultaneous events: reset dominates everything. A row change on a non-tick cycle is ignored until the next tick.
- Second key pressed while first held: ignored. No event until full release.
- Divider keeps running in all states. Column freeze does not reset the divider.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined:
  - While in WAIT_REL and row_s still equals the latched pattern, a repeat counter runs on ticks.
  - Every REPEAT_TICKS ticks it re-pulses key_valid with the same key_code.
  - Any release or pattern change clears the repeat counter.
- Undefined: exactly one event per press; repeat counter and REPEAT_TICKS logic absent.

Decomposition:
- Package vm_keypad_pkg holds:
  - state encoding (SCAN, DEB_PRESS, EMIT, WAIT_REL);
  - COL_RESET=4'b1110;
  - ROW_IDLE=4'b1111;
  - KEY_CODE_W=4;
  - row-to-index function.
- One sub-module: scan_tick_gen (parameter CLK_DIV; ports clk, reset, tick). Reused for display multiplexing.

Test Plan:
All runs use CLK_DIV=4, DEBOUNCE_TICKS=3, row=1111 unless stated.
1. Hold reset=0 for 50 clks. Expect shift_col=1110, key_valid=0, key_held=0. Release reset. Expect shift_col to step 1110→1101→1011→0111→1110, one step every 4 clks.
2. Drive row=1101 while shift_col=1011 for 10 ticks, then row=1111. Expect:
   - exactly one key_valid pulse with key_code=4'b1001;
   - key_held=1 until 3 idle ticks after release;
   - shift_col frozen at 1011 throughout, then rotating to 0111.
3. Drive row=1110 for 1 tick (bounce), then 1111. Expect no key_valid, key_held=0, scanning resumes.
4. Drive row=1100 for 10 ticks. Expect no key_valid, shift_col frozen, return to SCAN 3 ticks after release.
5. Assert reset=0 mid-WAIT_REL. Expect shift_col=1110 and key_held=0 in the same cycle (async), with no key_valid after reset exits while row is still low. Scanning resumes only after release debounce.
6. With KEYPAD_REPEAT_EN and REPEAT_TICKS=5, hold row=0111 on col 0 for 20 ticks. Expect key_code=4'b0011 pulses at acceptance, then every 5 ticks (4 pulses total). Without the macro, expect 1 pulse.
